// File: rtl/ex_div_unit.sv
// EX-stage iterative divider for DIV/DIVU: 32 restoring iterations, stalls the
// pipeline while busy and writes quotient (LO) / remainder (HI) on completion.
module ex_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             stallreq_for_ex,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state, state_next;
  logic [5:0]       cnt;
  logic             sdiv_r, dvd_neg, dsr_neg;
  logic [WIDTH-1:0] quo_r, dsr_r;
  logic [WIDTH:0]   rem_r;

  logic [WIDTH-1:0] dvd_abs, dsr_abs;
  logic [WIDTH:0]   rem_sh, rem_nx;
  logic [WIDTH-1:0] quo_sh, quo_nx, q_fix, r_fix, zero_rem;
  logic [WIDTH+1:0] trial;

  assign stallreq_for_ex = start & ~annul & (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (annul) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = (divisor == '0) ? ZERO : RUN;
        ZERO:    state_next = DONE;
        RUN:     if (cnt == 6'd31) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // One restoring step plus the sign fix-up applied to its result.
  always_comb begin
    dvd_abs  = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    dsr_abs  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
    rem_sh   = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    quo_sh   = {quo_r[WIDTH-2:0], 1'b0};
    trial    = {1'b0, rem_sh} - {2'b00, dsr_r};
    rem_nx   = rem_sh;
    quo_nx   = quo_sh;
    if (!trial[WIDTH+1]) begin
      rem_nx = trial[WIDTH:0];
      quo_nx = quo_sh | WIDTH'(1);
    end
    q_fix    = (sdiv_r && (dvd_neg ^ dsr_neg)) ? -quo_nx : quo_nx;
    r_fix    = (sdiv_r && dvd_neg) ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
    // Divide-by-zero returns the original dividend, rebuilt from its magnitude.
    zero_rem = (sdiv_r && dvd_neg) ? -quo_r : quo_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sdiv_r    <= 1'b0;
      dvd_neg   <= 1'b0;
      dsr_neg   <= 1'b0;
      quo_r     <= '0;
      dsr_r     <= '0;
      rem_r     <= '0;
      ready     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (state_next != IDLE) begin
            sdiv_r  <= signed_div;
            dvd_neg <= dividend[WIDTH-1];
            dsr_neg <= divisor[WIDTH-1];
            quo_r   <= dvd_abs;
            dsr_r   <= dsr_abs;
            rem_r   <= '0;
            cnt     <= '0;
          end
        end
        RUN: begin
          rem_r <= rem_nx;
          quo_r <= quo_nx;
          cnt   <= cnt + 6'd1;
          if (state_next == DONE) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            ready     <= 1'b1;
          end
        end
        ZERO: begin
          if (state_next == DONE) begin
            quotient  <= '1;
            remainder <= zero_rem;
            ready     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: vector table plus annul, reset and
// back-to-back sequences.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, signed_div, annul;
  logic [31:0] dividend, divisor;
  logic        stallreq_for_ex, ready;
  logic [31:0] quotient, remainder;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .dividend(dividend), .divisor(divisor), .annul(annul),
    .stallreq_for_ex(stallreq_for_ex), .ready(ready),
    .quotient(quotient), .remainder(remainder)
  );

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide from IDLE, hold start until ready, then drop start.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input int lat,
                         input string nm);
    int got;
    got = -1;
    start = 1'b1; signed_div = sd; dividend = a; divisor = b;
    for (int c = 0; c <= lat + 3 && got < 0; c++) begin
      #2;
      chk({nm, " stall"}, 32'(stallreq_for_ex), 32'(c < lat));
      if (ready) begin
        got = c;
        chk({nm, " quotient"}, quotient, q);
        chk({nm, " remainder"}, remainder, r);
      end
      next_cycle();
    end
    start = 1'b0;
    chk({nm, " ready cycle"}, 32'(got), 32'(lat));
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      #2;
      if (ready) pulses++;
      next_cycle();
    end
  endtask

  initial begin
    int pulses, r1, r2;
    logic [31:0] q1, q2, m1, m2;

    vt[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         33};
    vt[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vt[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         33};
    vt[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33};
    vt[4]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    vt[5]  = '{1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 2};
    vt[6]  = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 2};
    vt[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         33};
    vt[8]  = '{1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 33};
    vt[9]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 33};
    vt[10] = '{1'b0, 32'd5,         32'd7,         32'd0,         32'd5,         33};

    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    dividend = '0; divisor = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #2;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset stall", 32'(stallreq_for_ex), 32'd0);
    next_cycle();

    foreach (vt[i]) run_div(vt[i].sd, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].lat,
                            $sformatf("vec%0d", i));

    // Annul at cycle 10 of a run; the restart in cycle 11 proves IDLE was reached.
    run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33, "pre_annul");
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    for (int c = 0; c < 10; c++) next_cycle();
    annul = 1'b1;
    #2;
    chk("annul stall", 32'(stallreq_for_ex), 32'd0);
    next_cycle();
    annul = 1'b0;
    #2;
    chk("annul ready", 32'(ready), 32'd0);
    chk("annul quotient kept", quotient, 32'd2);
    chk("annul remainder kept", remainder, 32'd1);
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, "after_annul");

    // start and annul together in IDLE must not begin a division.
    start = 1'b1; annul = 1'b1; dividend = 32'd50; divisor = 32'd5;
    #2;
    chk("start+annul stall", 32'(stallreq_for_ex), 32'd0);
    next_cycle();
    start = 1'b0; annul = 1'b0;
    count_ready(40, pulses);
    chk("start+annul ready pulses", 32'(pulses), 32'd0);

    // Reset at cycle 20 abandons the division.
    start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
    for (int c = 0; c < 20; c++) next_cycle();
    rst = 1'b1; start = 1'b0;
    next_cycle();
    #2;
    chk("midrst ready", 32'(ready), 32'd0);
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    rst = 1'b0;
    next_cycle();
    count_ready(40, pulses);
    chk("midrst ready pulses", 32'(pulses), 32'd0);

    // Back-to-back: start held continuously, operands switch after first result.
    r1 = -1; r2 = -1; q1 = '0; q2 = '0; m1 = '0; m2 = '0;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
    for (int c = 0; c <= 70 && r2 < 0; c++) begin
      #2;
      chk("b2b stall", 32'(stallreq_for_ex), 32'((c < 33) || (c >= 34 && c < 67)));
      if (ready) begin
        if (r1 < 0) begin
          r1 = c; q1 = quotient; m1 = remainder;
          dividend = 32'd9; divisor = 32'd4;
        end else begin
          r2 = c; q2 = quotient; m2 = remainder;
        end
      end
      next_cycle();
    end
    start = 1'b0;
    chk("b2b first ready cycle", 32'(r1), 32'd33);
    chk("b2b first quotient", q1, 32'd10);
    chk("b2b first remainder", m1, 32'd0);
    chk("b2b second ready cycle", 32'(r2), 32'd67);
    chk("b2b second quotient", q2, 32'd2);
    chk("b2b second remainder", m2, 32'd1);
    count_ready(5, pulses);
    chk("b2b no extra ready", 32'(pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
